mem_burst_arbiter: RTL and testbench

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

---
 rtl/mem_burst_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter.sv
// Two-requester burst arbiter driving a single-port memory with fixed-length bursts.
// Define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mem_burst_arbiter #(
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [1:0]        done
);

    localparam int unsigned BEAT_W = $clog2(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain, StTurn} state_e;

    state_e              state_q, state_d;
    logic                winner_q, winner_d;
    logic                dir_we_q, dir_we_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic                pick;
    logic [1:0]          owner_oh;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = ~req[0];
    end
`else
    // prio_q names the requester that wins the next tie.
    logic prio_q, prio_d;

    always_comb begin
        if (req == 2'b11) begin
            pick = prio_q;
        end else begin
            pick = req[1];
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (state_q == StIdle && |req) begin
            prio_d = ~pick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign owner_oh = winner_q ? 2'b10 : 2'b01;

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        dir_we_d  = dir_we_q;
        base_d    = base_q;
        beat_d    = beat_q;
        gnt_d     = gnt_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        done      = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    winner_d = pick;
                    dir_we_d = pick ? req_we[1] : req_we[0];
                    base_d   = pick ? req_addr1 : req_addr0;
                    beat_d   = '0;
                    gnt_d    = pick ? 2'b10 : 2'b01;
                    state_d  = StBurst;
                end
            end
            StBurst: begin
                mem_re   = ~dir_we_q;
                mem_we   = dir_we_q;
                mem_addr = base_q + ADDR_W'(beat_q);
                beat_d   = beat_q + BEAT_W'(1);
                if (beat_q == LAST_BEAT) begin
                    if (dir_we_q) begin
                        done    = owner_oh;
                        gnt_d   = 2'b00;
                        state_d = StTurn;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Last read beat's data lands here alongside completion.
                done    = owner_oh;
                gnt_d   = 2'b00;
                state_d = StTurn;
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rvalid_d  = mem_re ? owner_oh : 2'b00;
        mem_wdata = '0;
        if (mem_we) begin
            mem_wdata = winner_q ? req_wdata1 : req_wdata0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            winner_q <= 1'b0;
            dir_we_q <= 1'b0;
            base_q   <= '0;
            beat_q   <= '0;
            gnt_q    <= 2'b00;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            dir_we_q <= dir_we_d;
            base_q   <= base_d;
            beat_q   <= beat_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;

    a_strobe_excl : assert property (@(posedge clk) disable iff (rst) !(mem_re && mem_we));
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_addr_idle   : assert property (@(posedge clk) disable iff (rst)
                                     !(mem_re || mem_we) |-> (mem_addr == '0));
    a_rdata_known : assert property (@(posedge clk) disable iff (rst)
                                     |rvalid |-> !$isunknown(mem_rdata));

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Randomised and directed bench for mem_burst_arbiter against a transaction-level model.
module tb_mem_burst_arbiter;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 32;
    localparam int          L      = 18;
    localparam int          OBS_W  = 2 + ADDR_W + DATA_W + 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req = 2'b00;
    logic [1:0]        req_we = 2'b00;
    logic [ADDR_W-1:0] req_addr0 = '0;
    logic [ADDR_W-1:0] req_addr1 = '0;
    logic [DATA_W-1:0] req_wdata0 = '0;
    logic [DATA_W-1:0] req_wdata1 = '0;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [1:0]        gnt, rvalid, done;

    int n_cmp  = 0;
    int n_fail = 0;

    // Transaction-level model: one active burst, indexed by cycle offset from IDLE exit.
    bit                m_active = 0;
    int                m_t = 0;
    int                m_who = 0;
    bit                m_we = 0;
    logic [ADDR_W-1:0] m_base = '0;
    int                m_prio = 0;

    logic [OBS_W-1:0]  obs, exp_v;
    logic              o_re, o_we;
    logic [ADDR_W-1:0] o_addr;
    logic [1:0]        o_gnt, o_rvalid, o_done;

    mem_burst_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(L)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .gnt(gnt), .rvalid(rvalid), .done(done)
    );

    always #5 clk = ~clk;

    // Structural invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            n_cmp = n_cmp + 3;
            if ((mem_re & mem_we) !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_strobe re=%b we=%b required not both", mem_re, mem_we);
            end
            if ($countones(gnt) > 1 || $isunknown(gnt)) begin
                n_fail++;
                $display("FAIL inv_gnt gnt=%b required one-hot-or-zero", gnt);
            end
            if (!mem_we && mem_wdata !== '0) begin
                n_fail++;
                $display("FAIL inv_wdata wdata=%h required 0", mem_wdata);
            end
        end
    end

    // Samples DUT and model expectation for the current cycle, then advances one clock.
    task automatic cycle();
        logic [1:0]        oh;
        logic              e_re, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wdata;
        logic [1:0]        e_gnt, e_rvalid, e_done;
        int                len;
        mem_rdata = $urandom;
        #2;
        e_re = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        e_gnt = 0; e_rvalid = 0; e_done = 0;
        oh  = (m_who == 1) ? 2'b10 : 2'b01;
        len = m_we ? L + 1 : L + 2;
        if (m_active) begin
            if (m_t < L) begin
                e_re   = !m_we;
                e_we   = m_we;
                e_addr = m_base + ADDR_W'(m_t);
                if (m_we) e_wdata = (m_who == 1) ? req_wdata1 : req_wdata0;
            end
            if (m_t < (m_we ? L : L + 1)) e_gnt = oh;
            if (!m_we && m_t >= 1 && m_t <= L) e_rvalid = oh;
            if (m_t == (m_we ? L - 1 : L)) e_done = oh;
        end
        exp_v = {e_re, e_we, e_addr, e_wdata, e_gnt, e_rvalid, e_done};
        obs   = {mem_re, mem_we, mem_addr, mem_wdata, gnt, rvalid, done};
        o_re = mem_re; o_we = mem_we; o_addr = mem_addr;
        o_gnt = gnt; o_rvalid = rvalid; o_done = done;
        if (rst) begin
            m_active = 0;
            m_prio   = 0;
        end else if (m_active) begin
            m_t++;
            if (m_t == len) m_active = 0;
        end else if (req != 2'b00) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            m_who = req[0] ? 0 : 1;
`else
            m_who  = (req == 2'b11) ? m_prio : (req[0] ? 0 : 1);
            m_prio = 1 - m_who;
`endif
            m_we     = req_we[m_who];
            m_base   = (m_who == 1) ? req_addr1 : req_addr0;
            m_active = 1;
            m_t      = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; req = 2'b00;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            req = 2'($urandom); req_we = 2'($urandom);
            cycle();
            n_cmp++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs got=%h required 0", obs);
            end
        end
        rst = 0; req = 2'b00;
    endtask

    task automatic test_single_read();
        int nre = 0, nrv = 0, ndone = 0;
        bit drain_ok = 0;
        logic [ADDR_W-1:0] first_a = '1, last_a = '0;
        rst = 1; cycle(); rst = 0;
        req = 2'b01; req_we = 2'b00; req_addr0 = 19'h00100;
        for (int i = 0; i < 25; i++) begin
            cycle();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL read_cycle%0d got=%h required %h", i, obs, exp_v);
            end
            if (o_re) begin
                if (nre == 0) first_a = o_addr;
                last_a = o_addr;
                nre++;
            end
            if (o_rvalid[0]) nrv++;
            if (o_done[0]) begin
                ndone++;
                drain_ok = !o_re && o_rvalid[0];
                req = 2'b00;
            end
        end
        n_cmp = n_cmp + 6;
        if (nre != 18) begin n_fail++; $display("FAIL read_beats got=%0d required 18", nre); end
        if (nrv != 18) begin n_fail++; $display("FAIL read_rvalid got=%0d required 18", nrv); end
        if (first_a !== 19'h00100) begin
            n_fail++; $display("FAIL read_first_addr got=%h required 00100", first_a);
        end
        if (last_a !== 19'h00111) begin
            n_fail++; $display("FAIL read_last_addr got=%h required 00111", last_a);
        end
        if (ndone != 1) begin n_fail++; $display("FAIL read_done got=%0d required 1", ndone); end
        if (!drain_ok) begin n_fail++; $display("FAIL read_done_in_drain got=0 required 1"); end
    endtask

    task automatic test_single_write();
        int nwe = 0, ndone = 0;
        bit done_last = 0;
        logic [ADDR_W-1:0] a7 = '1, a8 = '1, a17 = '1;
        rst = 1; cycle(); rst = 0;
        req = 2'b10; req_we = 2'b10; req_addr1 = 19'h7FFF8;
        for (int i = 0; i < 24; i++) begin
            req_wdata1 = $urandom; req_wdata0 = $urandom;
            cycle();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL write_cycle%0d got=%h required %h", i, obs, exp_v);
            end
            if (o_we) begin
                if (nwe == 7) a7 = o_addr;
                if (nwe == 8) a8 = o_addr;
                if (nwe == 17) a17 = o_addr;
                nwe++;
            end
            if (o_done[1]) begin
                ndone++;
                done_last = o_we && o_addr == 19'h00009;
                req = 2'b00;
            end
        end
        n_cmp = n_cmp + 6;
        if (nwe != 18) begin n_fail++; $display("FAIL write_beats got=%0d required 18", nwe); end
        if (a7 !== 19'h7FFFF) begin n_fail++; $display("FAIL write_a7 got=%h required 7ffff", a7); end
        if (a8 !== 19'h00000) begin n_fail++; $display("FAIL write_wrap got=%h required 0", a8); end
        if (a17 !== 19'h00009) begin n_fail++; $display("FAIL write_a17 got=%h required 9", a17); end
        if (ndone != 1) begin n_fail++; $display("FAIL write_done got=%0d required 1", ndone); end
        if (!done_last) begin n_fail++; $display("FAIL write_done_last_beat got=0 required 1"); end
    endtask

    task automatic test_arbitration();
        int got[4];
        int ng = 0;
        int want;
        logic [1:0] prev = 2'b00;
        rst = 1; req = 2'b00; cycle(); rst = 0;
        req = 2'b11; req_we = 2'b01;
        req_addr0 = 19'($urandom); req_addr1 = 19'($urandom);
        for (int i = 0; i < 150 && ng < 4; i++) begin
            req_wdata0 = $urandom; req_wdata1 = $urandom;
            cycle();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL arb_cycle%0d got=%h required %h", i, obs, exp_v);
            end
            if (prev == 2'b00 && o_gnt != 2'b00) begin
                got[ng] = o_gnt[1] ? 1 : 0;
                ng++;
            end
            prev = o_gnt;
        end
        n_cmp++;
        if (ng != 4) begin
            n_fail++;
            $display("FAIL arb_timeout grants=%0d required 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            want = 0;
`else
            want = i % 2;
`endif
            n_cmp++;
            if (got[i] != want) begin
                n_fail++;
                $display("FAIL arb_grant%0d got=%0d required %0d", i, got[i], want);
            end
        end
    endtask

    task automatic test_req_drop();
        int nbeat = 0, ndone = 0;
        logic [ADDR_W-1:0] base;
        rst = 1; req = 2'b00; cycle(); rst = 0;
        base = 19'($urandom);
        req = 2'b01; req_we = 2'($urandom); req_addr0 = base;
        for (int i = 0; i < 30; i++) begin
            req_wdata0 = $urandom;
            cycle();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL drop_cycle%0d got=%h required %h", i, obs, exp_v);
            end
            if (o_re || o_we) begin
                nbeat++;
                if (o_addr == base + 19'd5) begin
                    req = 2'b00;
                    req_addr0 = 19'($urandom);
                    req_we = 2'($urandom);
                end
            end
            if (o_done[0]) ndone++;
        end
        n_cmp = n_cmp + 2;
        if (nbeat != 18) begin n_fail++; $display("FAIL drop_beats got=%0d required 18", nbeat); end
        if (ndone != 1) begin n_fail++; $display("FAIL drop_done got=%0d required 1", ndone); end
    endtask

    task automatic test_reset_mid_burst();
        int nbeat = 0, ndone_pre = 0, ndone = 0;
        bit hit = 0;
        logic [ADDR_W-1:0] base, first_a = '1;
        rst = 1; req = 2'b00; cycle(); rst = 0;
        base = 19'($urandom);
        req = 2'b01; req_we = 2'b00; req_addr0 = base;
        for (int i = 0; i < 15 && !hit; i++) begin
            cycle();
            if (o_done != 2'b00) ndone_pre++;
            if (o_re && o_addr == base + 19'd8) hit = 1;
        end
        n_cmp++;
        if (!hit) begin n_fail++; $display("FAIL rstmid_timeout got=0 required beat 8"); end
        rst = 1;
        cycle();
        n_cmp++;
        if (o_done !== 2'b00) begin
            n_fail++; $display("FAIL rstmid_done_at_reset got=%b required 00", o_done);
        end
        rst = 0;
        cycle();
        n_cmp = n_cmp + 2;
        if (obs !== '0) begin n_fail++; $display("FAIL rstmid_zero got=%h required 0", obs); end
        if (ndone_pre != 0) begin
            n_fail++; $display("FAIL rstmid_no_done got=%0d required 0", ndone_pre);
        end
        for (int i = 0; i < 25; i++) begin
            cycle();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rstmid_cycle%0d got=%h required %h", i, obs, exp_v);
            end
            if (o_re) begin
                if (nbeat == 0) first_a = o_addr;
                nbeat++;
            end
            if (o_done[0]) begin ndone++; req = 2'b00; end
        end
        n_cmp = n_cmp + 3;
        if (first_a !== base) begin
            n_fail++; $display("FAIL rstmid_restart_addr got=%h required %h", first_a, base);
        end
        if (nbeat != 18) begin n_fail++; $display("FAIL rstmid_beats got=%0d required 18", nbeat); end
        if (ndone != 1) begin n_fail++; $display("FAIL rstmid_done got=%0d required 1", ndone); end
    endtask

    task automatic test_random();
        rst = 1; req = 2'b00; cycle(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 2'($urandom);
            req_we     = 2'($urandom);
            req_addr0  = 19'($urandom);
            req_addr1  = ($urandom_range(0, 3) == 0) ? 19'h7FFF0 : 19'($urandom);
            req_wdata0 = $urandom;
            req_wdata1 = $urandom;
            rst        = ($urandom_range(0, 99) == 0);
            cycle();
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rand_cycle%0d got=%h required %h", i, obs, exp_v);
            end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_arbitration();
        test_req_drop();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
